// File: rtl/segway_pkg.sv
// rtl/segway_pkg.sv - shared types and default constants for the Segway control blocks
package segway_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        STEER = 2'b10
    } steer_state_t;

    localparam logic [11:0] MIN_RIDER_WT_DEF = 12'h200;
    localparam logic [11:0] HYST_DEF         = 12'h040;
    localparam int          TMR_W_FULL       = 26;
    localparam int          TMR_W_SIM        = 15;

endpackage

// File: rtl/steer_ld_cmp.sv
// rtl/steer_ld_cmp.sv - load-cell sum/diff arithmetic and registered weight/balance flags
module steer_ld_cmp
    import segway_pkg::*;
#(
    parameter int              LC_W         = 12,
    parameter logic [LC_W-1:0] MIN_RIDER_WT = LC_W'(MIN_RIDER_WT_DEF),
    parameter logic [LC_W-1:0] HYST         = LC_W'(HYST_DEF)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [LC_W-1:0] lft_ld,
    input  logic [LC_W-1:0] rght_ld,
    input  logic            ld_vld,
    output logic            sum_gt_min,
    output logic            sum_lt_min,
    output logic            diff_gt_1_4,
    output logic            diff_gt_15_16
);

    // Thresholds live one bit wider than a reading so the sum never overflows.
    localparam logic [LC_W:0] THR_HI = {1'b0, MIN_RIDER_WT} + {1'b0, HYST};
    localparam logic [LC_W:0] THR_LO = {1'b0, MIN_RIDER_WT} - {1'b0, HYST};

    logic [LC_W:0]   sum;
    logic [LC_W-1:0] diff;
    logic [LC_W:0]   diff_ext;

    assign sum      = {1'b0, lft_ld} + {1'b0, rght_ld};
    assign diff     = (lft_ld >= rght_ld) ? (lft_ld - rght_ld) : (rght_ld - lft_ld);
    assign diff_ext = {1'b0, diff};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_gt_min    <= 1'b0;
            sum_lt_min    <= 1'b0;
            diff_gt_1_4   <= 1'b0;
            diff_gt_15_16 <= 1'b0;
        end else if (ld_vld) begin
            sum_gt_min    <= (sum > THR_HI);
            sum_lt_min    <= (sum < THR_LO);
            diff_gt_1_4   <= (diff_ext > (sum >> 2));
            diff_gt_15_16 <= (diff_ext > (sum - (sum >> 4)));
        end
    end

endmodule

// File: rtl/steer_en_ctrl.sv
// rtl/steer_en_ctrl.sv - rider-detection state machine with settle timer driving steering enable
module steer_en_ctrl
    import segway_pkg::*;
#(
    parameter int              LC_W         = 12,
    parameter logic [LC_W-1:0] MIN_RIDER_WT = LC_W'(MIN_RIDER_WT_DEF),
    parameter logic [LC_W-1:0] HYST         = LC_W'(HYST_DEF),
    parameter bit              FAST_SIM     = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [LC_W-1:0] lft_ld,
    input  logic [LC_W-1:0] rght_ld,
    input  logic            ld_vld,
    output logic            en_steer,
    output logic            rider_off,
    output logic [1:0]      sm_state
);

    localparam int TMR_W = FAST_SIM ? TMR_W_SIM : TMR_W_FULL;

    logic             sum_gt_min;
    logic             sum_lt_min;
    logic             diff_gt_1_4;
    logic             diff_gt_15_16;
    logic [TMR_W-1:0] timer;
    logic             tmr_full;
    steer_state_t     state;
    steer_state_t     nxt_state;

    steer_ld_cmp #(
        .LC_W         (LC_W),
        .MIN_RIDER_WT (MIN_RIDER_WT),
        .HYST         (HYST)
    ) u_ld_cmp (
        .clk           (clk),
        .rst_n         (rst_n),
        .lft_ld        (lft_ld),
        .rght_ld       (rght_ld),
        .ld_vld        (ld_vld),
        .sum_gt_min    (sum_gt_min),
        .sum_lt_min    (sum_lt_min),
        .diff_gt_1_4   (diff_gt_1_4),
        .diff_gt_15_16 (diff_gt_15_16)
    );

    assign tmr_full = &timer;

    // Settle timer only runs while the rider stands balanced in WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if ((state != WAIT) || diff_gt_1_4) begin
            timer <= '0;
        end else if (!tmr_full) begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    // A weight drop outranks every balance condition in every state.
    always_comb begin
        nxt_state = state;
        case (state)
            IDLE: begin
                if (sum_gt_min) nxt_state = WAIT;
            end
            WAIT: begin
                if (sum_lt_min)       nxt_state = IDLE;
                else if (diff_gt_1_4) nxt_state = WAIT;
                else if (tmr_full)    nxt_state = STEER;
            end
            STEER: begin
                if (sum_lt_min)         nxt_state = IDLE;
                else if (diff_gt_15_16) nxt_state = WAIT;
            end
            default: nxt_state = IDLE;
        endcase
    end

    assign en_steer  = (state == STEER);
    assign rider_off = (state == IDLE);
    assign sm_state  = state;

endmodule

// File: tb/tb_steer_en_ctrl.sv
// tb/tb_steer_en_ctrl.sv - directed self-checking bench for steer_en_ctrl with FAST_SIM timer
module tb_steer_en_ctrl;
    import segway_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] lft_ld = '0;
    logic [11:0] rght_ld = '0;
    logic        ld_vld = 1'b0;
    logic        en_steer;
    logic        rider_off;
    logic [1:0]  sm_state;

    int vectors = 0;
    int miscompares = 0;

    steer_en_ctrl #(
        .LC_W     (12),
        .FAST_SIM (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .ld_vld    (ld_vld),
        .en_steer  (en_steer),
        .rider_off (rider_off),
        .sm_state  (sm_state)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [11:0] l, input logic [11:0] r);
        lft_ld  = l;
        rght_ld = r;
        ld_vld  = 1'b1;
        step();
        ld_vld  = 1'b0;
    endtask

    initial begin
        // Reset state
        #5;
        check("rst_en", 32'(en_steer), 32'd0);
        check("rst_rider_off", 32'(rider_off), 32'd1);
        check("rst_state", 32'(sm_state), 32'd0);
        check("rst_timer", 32'(dut.timer), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Light load stays IDLE
        strobe(12'h0C0, 12'h0C0);
        step();
        step();
        check("light_idle", 32'(sm_state), 32'd0);

        // Rider mounts: WAIT on second edge, STEER exactly 2^15 edges later
        strobe(12'h130, 12'h130);
        check("mount_edge1", 32'(sm_state), 32'd0);
        step();
        check("mount_wait", 32'(sm_state), 32'd1);
        check("mount_rider_off", 32'(rider_off), 32'd0);
        check("mount_timer0", 32'(dut.timer), 32'd0);
        repeat (32767) step();
        check("settle_pre_en", 32'(en_steer), 32'd0);
        check("settle_pre_timer", 32'(dut.timer), 32'd32767);
        check("settle_pre_rider_off", 32'(rider_off), 32'd0);
        step();
        check("settle_en", 32'(en_steer), 32'd1);
        check("settle_state", 32'(sm_state), 32'd2);

        // In-band sum while steering holds STEER
        strobe(12'h100, 12'h0F0);
        repeat (3) step();
        check("band_hold_state", 32'(sm_state), 32'd2);
        check("band_hold_en", 32'(en_steer), 32'd1);

        // Severe imbalance drops back to WAIT
        strobe(12'h260, 12'h000);
        step();
        check("imbal_state", 32'(sm_state), 32'd1);
        check("imbal_en", 32'(en_steer), 32'd0);
        check("imbal_timer", 32'(dut.timer), 32'd0);

        // Disturbance mid-settle clears the timer, then a full settle again
        strobe(12'h130, 12'h130);
        check("rebal_timer0", 32'(dut.timer), 32'd0);
        repeat (1000) step();
        check("settle_timer_1000", 32'(dut.timer), 32'd1000);
        strobe(12'h200, 12'h060);
        step();
        check("disturb_timer", 32'(dut.timer), 32'd0);
        check("disturb_state", 32'(sm_state), 32'd1);
        strobe(12'h130, 12'h130);
        check("disturb_rebal_timer", 32'(dut.timer), 32'd0);
        repeat (32767) step();
        check("resettle_pre_en", 32'(en_steer), 32'd0);
        step();
        check("resettle_en", 32'(en_steer), 32'd1);

        // Weight drop from STEER goes straight to IDLE
        strobe(12'h0D0, 12'h0D0);
        step();
        check("drop_state", 32'(sm_state), 32'd0);
        check("drop_rider_off", 32'(rider_off), 32'd1);
        check("drop_en", 32'(en_steer), 32'd0);
        strobe(12'h1A0, 12'h000);
        repeat (2) step();
        check("drop_unbal_state", 32'(sm_state), 32'd0);

        // Back to STEER quickly by preloading the timer near full
        strobe(12'h130, 12'h130);
        step();
        check("remount_wait", 32'(sm_state), 32'd1);
        @(negedge clk);
        force dut.timer = 15'h7FF0;
        #1;
        release dut.timer;
        repeat (16) step();
        check("preload_steer", 32'(en_steer), 32'd1);

        // Asynchronous reset between edges
        #4;
        rst_n = 1'b0;
        #1;
        check("async_rst_en", 32'(en_steer), 32'd0);
        check("async_rst_rider_off", 32'(rider_off), 32'd1);
        check("async_rst_state", 32'(sm_state), 32'd0);
        check("async_rst_timer", 32'(dut.timer), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Illegal encoding recovers to IDLE on the next edge
        @(negedge clk);
        force dut.state = steer_state_t'(2'b11);
        #1;
        check("illegal_visible", 32'(sm_state), 32'd3);
        release dut.state;
        step();
        check("illegal_recover", 32'(sm_state), 32'd0);
        check("illegal_rider_off", 32'(rider_off), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/steer_en_ctrl.md
Name: steer_en_ctrl

Overview:
- Parametrised steering-enable controller for the Segway.
- Consumes raw left/right load-cell readings and computes its own hysteretic weight flags and difference flags.
- Contains its own settle timer and runs the IDLE/WAIT/STEER rider-detection state machine.
- Drives en_steer to balance_cntrl and rider_off to the piezo/auth logic.

Parameters:
- LC_W, 12, width of each load-cell reading (unsigned).
- MIN_RIDER_WT, 12'h200, minimum rider weight threshold on the sum lft_ld+rght_ld.
- HYST, 12'h040, hysteresis half-band around MIN_RIDER_WT.
- FAST_SIM, 0, if 1 the timer is 15 bits (sim); if 0 it is 26 bits (~1.34 s at 50 MHz).

Ports:
- clk  in  1  50 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- lft_ld  in  LC_W  left load-cell reading, unsigned
- rght_ld  in  LC_W  right load-cell reading, unsigned
- ld_vld  in  1  one-cycle strobe; lft_ld/rght_ld valid this cycle
- en_steer  out  1  steering enable, high only in STEER
- rider_off  out  1  high in IDLE (no rider)
- sm_state  out  2  current state encoding, for debug/visibility

Behaviour:
- Reset: rst_n is asynchronous, active-low; the clock is clk.
  - Reset values: state=IDLE, timer=0, all flags=0, en_steer=0, rider_off=1, sm_state=IDLE.
- Arithmetic, evaluated on the cycle ld_vld=1:
  - sum = lft_ld+rght_ld, width LC_W+1, so no overflow.
  - diff = |lft_ld-rght_ld|, width LC_W.
- Flags (registered, loaded only when ld_vld=1, held otherwise; 1-cycle latency from the ld_vld cycle):
  - sum_gt_min = sum > MIN_RIDER_WT+HYST
  - sum_lt_min = sum < MIN_RIDER_WT-HYST
  - diff_gt_1_4 = diff > (sum>>2)
  - diff_gt_15_16 = diff > sum-(sum>>4)
  - All compares are unsigned. Threshold constants are extended to LC_W+1 bits.
- Hysteresis: a sum inside the band [MIN-HYST, MIN+HYST] asserts neither weight flag. The state machine then holds its state with respect to weight.
- Timer:
  - TMR_W = FAST_SIM ? 15 : 26.
  - Cleared to 0 on every cycle the state is not WAIT, and on any WAIT cycle that has diff_gt_1_4=1.
  - Otherwise increments by 1 per WAIT cycle and saturates at all-ones.
  - tmr_full = (timer == all-ones).
- State machine: states IDLE=2'b00, WAIT=2'b01, STEER=2'b10; 2'b11 is illegal and recovers to IDLE next cycle. Transitions are evaluated every clk on the registered flags.
  - IDLE: sum_gt_min -> WAIT; else stay.
  - WAIT, in priority order: sum_lt_min -> IDLE; else diff_gt_1_4 -> stay (timer cleared); else tmr_full -> STEER; else stay.
  - STEER, in priority order: sum_lt_min -> IDLE; else diff_gt_15_16 -> WAIT (timer restarts from 0); else stay.
- Outputs are Moore, decoded from the registered state; they change on the clk edge that enters the state.
  - en_steer = (state==STEER)
  - rider_off = (state==IDLE)
  - sm_state = state
- Settle timing: the timer reads 0 on the first WAIT cycle. With no disturbing flags, en_steer rises exactly 2^TMR_W cycles after the WAIT entry edge.
- Simultaneous events: sum_lt_min beats every other condition. A diff flag during a weight drop has no effect.
- Reset mid-operation: en_steer drops and rider_off rises asynchronously at rst_n fall.

Decomposition:
- Shared package (segway_pkg):
  - steer_state_t enum {IDLE, WAIT, STEER}, 2-bit.
  - Default MIN_RIDER_WT/HYST localparams.
  - TMR_W_FULL=26, TMR_W_SIM=15.
- One sub-module, steer_ld_cmp: combinational sum/diff plus the registered flag stage. Ports: clk, rst_n, lft_ld, rght_ld, ld_vld, and the four flags.
- The timer and the state machine live in the top module.

Test Plan (FAST_SIM=1, defaults):
- Reset with rst_n=0 -> en_steer=0, rider_off=1, sm_state=00. Then ld 0x0C0/0x0C0 (sum 0x180) strobed -> remains IDLE.
- ld 0x130/0x130 (sum 0x260) strobed, then held -> WAIT on the 2nd edge after the strobe. en_steer=1 exactly 32768 cycles after WAIT entry; rider_off=0 throughout.
- In WAIT, at timer≈20000, strobe ld 0x200/0x060 (diff 0x1A0 > sum/4=0x98) -> timer reads 0. Then re-strobe balanced 0x130/0x130 -> STEER 32768 cycles after the first timer increment.
- In STEER, strobe ld 0x260/0x000 (diff 0x260 > 0x23A) -> sm_state=01, en_steer=0, timer 0. Also strobe 0x100/0x0F0 (sum 0x1F0, inside the band) -> state held, no IDLE.
- In STEER, strobe ld 0x0D0/0x0D0 (sum 0x1A0 < 0x1C0) -> IDLE, rider_off=1. Repeat the same sum together with an unbalanced diff -> still IDLE (priority).
- Assert rst_n=0 mid-STEER, asynchronously between edges -> en_steer falls immediately, state=IDLE, timer=0. Force illegal state 11 -> IDLE next cycle.
